seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider: quotient = dividend / divisor, remainder = dividend mod divisor.
- Each iteration performs one trial subtraction on an add/sub unit held in subtract mode, so this block is the sequential inverse-operation companion to the combinational add/sub datapath.
- Sits beside the add/sub unit in the arithmetic datapath.
- Uses a start/busy/done handshake, one quotient bit per clock.

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_add_sub_unit.sv | 19 +
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider and its add/sub datapath.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic SUB_MODE = 1'b1;

endpackage

// File: rtl/seq_divider_add_sub_unit.sv
// Parameterised add/subtract unit; control_in=1 computes a-b with carry_out=1 meaning no borrow.
module add_sub_unit #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             control_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff = b_in ^ {WIDTH{control_in}};
        {carry_out, sum_out} = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, control_in};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_by_zero_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state, next_state;
    logic             accept;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    add_sub_unit #(.WIDTH(WIDTH + 1)) u_add_sub (
        .a_in       (rem_shift),
        .b_in       ({1'b0, dvsr}),
        .control_in (SUB_MODE),
        .sum_out    (trial),
        .carry_out  (no_borrow)
    );

    // Restoring step: the partial remainder never exceeds the divisor, so its top bit
    // is always shifted out as zero.
    always_comb begin
        rem_shift = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
        rem_next  = no_borrow ? trial : rem_shift;
        quo_next  = {quo[WIDTH-2:0], no_borrow};
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (start_in) begin
                    accept     = 1'b1;
                    next_state = (divisor_in == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            count           <= '0;
            rem             <= '0;
            quo             <= '0;
            dvsr            <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            quotient_out    <= '0;
            remainder_out   <= '0;
            div_by_zero_out <= 1'b0;
        end else begin
            busy_out <= (next_state == CALC);
            done_out <= (next_state == DONE);
            if (accept) begin
                dvsr <= divisor_in;
                if (divisor_in == '0) begin
                    quotient_out    <= '1;
                    remainder_out   <= dividend_in;
                    div_by_zero_out <= 1'b1;
                end else begin
                    rem             <= '0;
                    quo             <= dividend_in;
                    count           <= CNT_W'(WIDTH);
                    div_by_zero_out <= 1'b0;
                end
            end else if (state == CALC) begin
                rem   <= rem_next;
                quo   <= quo_next;
                count <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    quotient_out  <= quo_next;
                    remainder_out <= rem_next[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed divisions with hand-computed results and latency.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_in;
    logic         start_in;
    logic [W-1:0] dividend_in;
    logic [W-1:0] divisor_in;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] quotient_out;
    logic [W-1:0] remainder_out;
    logic         div_by_zero_out;

    typedef struct {
        string nm;
        int    q;
        int    r;
        int    dbz;
        int    cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .dividend_in     (dividend_in),
        .divisor_in      (divisor_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .quotient_out    (quotient_out),
        .remainder_out   (remainder_out),
        .div_by_zero_out (div_by_zero_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done_out=1 expected no pending result (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_quotient"},  int'(quotient_out),    e.q);
                chk({e.nm, "_remainder"}, int'(remainder_out),   e.r);
                chk({e.nm, "_dbz"},       int'(div_by_zero_out), e.dbz);
                chk({e.nm, "_latency"},   cyc,                   e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the following negedge with start dropped and operands scrambled.
    task automatic issue(input string nm, input int dvd, input int dvs,
                         input int eq, input int er, input int ed, input bit push);
        exp_t e;
        dividend_in = W'(dvd);
        divisor_in  = W'(dvs);
        start_in    = 1'b1;
        if (push) begin
            e.nm  = nm;
            e.q   = eq;
            e.r   = er;
            e.dbz = ed;
            e.cyc = cyc + 1 + ((dvs == 0) ? 0 : W);
            sb.push_back(e);
        end
        @(negedge clk);
        start_in    = 1'b0;
        dividend_in = ~dividend_in;
        divisor_in  = ~divisor_in;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string pfx);
        chk({pfx, "_busy"},      int'(busy_out),        0);
        chk({pfx, "_done"},      int'(done_out),        0);
        chk({pfx, "_quotient"},  int'(quotient_out),    0);
        chk({pfx, "_remainder"}, int'(remainder_out),   0);
        chk({pfx, "_dbz"},       int'(div_by_zero_out), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation time %0t expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_in    = 1'b1;
        start_in    = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        reset_in = 1'b0;
        @(negedge clk);

        // 13/3 with explicit busy window check
        issue("d13_3", 13, 3, 4, 1, 0, 1'b1);
        chk("d13_3_busy_c1", int'(busy_out), 1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("d13_3_busy_c%0d", i), int'(busy_out), 1);
        end
        @(negedge clk);
        chk("d13_3_busy_c5", int'(busy_out), 0);
        chk("d13_3_done_c5", int'(done_out), 1);
        drain();

        issue("d15_1",  15, 1,  15, 0, 0, 1'b1); drain();
        issue("d3_7",   3,  7,  0,  3, 0, 1'b1); drain();
        issue("d15_15", 15, 15, 1,  0, 0, 1'b1); drain();
        issue("d0_5",   0,  5,  0,  0, 0, 1'b1); drain();

        issue("d9_0",   9,  0,  15, 9, 1, 1'b1); drain();
        issue("d8_2",   8,  2,  4,  0, 0, 1'b1); drain();

        // start while busy is ignored; start during done is accepted back-to-back
        issue("d14_4", 14, 4, 3, 2, 0, 1'b1);
        @(negedge clk);
        dividend_in = 4'd1;
        divisor_in  = 4'd1;
        start_in    = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done_slot", int'(done_out), 1);
        issue("d12_5", 12, 5, 2, 2, 0, 1'b1);
        drain();

        // reset in the middle of a division
        issue("d15_2_abort", 15, 2, 0, 0, 0, 1'b0);
        @(negedge clk);
        reset_in = 1'b1;
        @(negedge clk);
        check_zero_outputs("midreset");
        reset_in = 1'b0;
        @(negedge clk);
        issue("d7_2", 7, 2, 3, 1, 0, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
